systolic_pq_kv: RTL

SYSTOLIC_PQ_KV -- requirements
Module: systolic_pq_kv

---
 rtl/systolic_pq_kv.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/systolic_pq_kv.sv
// Systolic key/value priority queue: N cells, each with an input (IB) and
// output (OB) slot; odd/even cells sort on alternating phases.
module systolic_pq_kv #(
   parameter int QUEUE_SIZE = 8,
   parameter int KEY_WIDTH  = 16,
   parameter int VAL_WIDTH  = 16,
   parameter int MIN_FIRST  = 1,
   localparam int CW = $clog2(2 * QUEUE_SIZE + 1)
) (
   input  logic                 CLK,
   input  logic                 RSTn,
   input  logic                 i_flush,
   input  logic                 i_push,
   input  logic                 i_pop,
   input  logic [KEY_WIDTH-1:0] i_key,
   input  logic [VAL_WIDTH-1:0] i_val,
   output logic                 o_top_valid,
   output logic [KEY_WIDTH-1:0] o_top_key,
   output logic [VAL_WIDTH-1:0] o_top_val,
   output logic [CW-1:0]        o_count,
   output logic                 o_full,
   output logic                 o_empty,
   output logic                 o_push_ready,
   output logic                 o_busy,
   output logic                 o_push_drop,
   output logic                 o_pop_drop
);

   localparam int N = QUEUE_SIZE;
   localparam logic [CW-1:0] CAP = CW'(2 * N);

   logic [N-1:0]         ib_v, ob_v, n_ib_v, n_ob_v;
   logic [KEY_WIDTH-1:0] ib_k [N];
   logic [KEY_WIDTH-1:0] ob_k [N];
   logic [KEY_WIDTH-1:0] n_ib_k [N];
   logic [KEY_WIDTH-1:0] n_ob_k [N];
   logic [VAL_WIDTH-1:0] ib_d [N];
   logic [VAL_WIDTH-1:0] ob_d [N];
   logic [VAL_WIDTH-1:0] n_ib_d [N];
   logic [VAL_WIDTH-1:0] n_ob_d [N];

   logic          phase, n_phase;
   logic [CW-1:0] count, n_count;
   logic          push_drop, pop_drop;
   logic          n_push_drop, n_pop_drop;

   logic [N-1:0] r1, r2, r3, act;
   logic do_push, do_pop, top_v;
   logic op_rep, op_ins, op_psh, op_pop, op_acc;

   function automatic logic better(
      input logic                 av,
      input logic [KEY_WIDTH-1:0] ak,
      input logic                 bv,
      input logic [KEY_WIDTH-1:0] bk
   );
      logic r;
      r = 1'b0;
      if (av) begin
         if (!bv)
            r = 1'b1;
         else if (MIN_FIRST != 0)
            r = (ak < bk);
         else
            r = (ak > bk);
      end
      return r;
   endfunction

   // Rule enables are evaluated for every cell regardless of phase
   always_comb begin
      r1 = '0;
      r2 = '0;
      r3 = '0;
      for (int i = 0; i < N; i++)
         r1[i] = better(ib_v[i], ib_k[i], ob_v[i], ob_k[i]);
      for (int i = 0; i < N - 1; i++) begin
         r2[i] = better(ob_v[i+1], ob_k[i+1], ob_v[i], ob_k[i]);
         r3[i] = ib_v[i] && !ib_v[i+1];
      end
   end

   assign o_busy       = |(r1 | r2 | r3);
   assign o_full       = (count == CAP);
   assign o_empty      = (count == '0);
   assign o_push_ready = !ib_v[0] && !o_full;
   assign o_count      = count;
   assign o_push_drop  = push_drop;
   assign o_pop_drop   = pop_drop;
   assign o_top_valid  = ob_v[0];
   assign o_top_key    = ob_v[0] ? ob_k[0] : '0;
   assign o_top_val    = ob_v[0] ? ob_d[0] : '0;

   // Pops are judged on the visible head so o_count always equals
   // the number of valid slots, even mid-sort.
   always_comb begin
      do_push     = i_push && !i_flush;
      do_pop      = i_pop && !i_flush;
      top_v       = ob_v[0];
      op_rep      = do_push && do_pop && top_v;
      op_ins      = do_push && do_pop && !top_v;
      op_psh      = do_push && !do_pop && o_push_ready;
      op_pop      = do_pop && !do_push && top_v;
      n_push_drop = do_push && !do_pop && !o_push_ready;
      n_pop_drop  = do_pop && !top_v;
      op_acc      = op_rep || op_ins || op_psh || op_pop;
   end

   always_comb begin
      act = '0;
      for (int i = 0; i < N; i++)
         act[i] = (1'(i) == phase) && !((i == 0) && op_acc);
   end

   always_comb begin
      n_ib_v  = ib_v;
      n_ob_v  = ob_v;
      n_ib_k  = ib_k;
      n_ob_k  = ob_k;
      n_ib_d  = ib_d;
      n_ob_d  = ob_d;
      n_count = count;
      n_phase = ~phase;
      for (int i = 0; i < N; i++) begin
         if (act[i]) begin
            if (r1[i]) begin
               n_ib_v[i] = ob_v[i];
               n_ib_k[i] = ob_k[i];
               n_ib_d[i] = ob_d[i];
               n_ob_v[i] = ib_v[i];
               n_ob_k[i] = ib_k[i];
               n_ob_d[i] = ib_d[i];
            end else if (r2[i]) begin
               n_ob_v[i]         = ob_v[(i+1)%N];
               n_ob_k[i]         = ob_k[(i+1)%N];
               n_ob_d[i]         = ob_d[(i+1)%N];
               n_ob_v[(i+1)%N]   = ob_v[i];
               n_ob_k[(i+1)%N]   = ob_k[i];
               n_ob_d[(i+1)%N]   = ob_d[i];
            end else if (r3[i]) begin
               n_ib_v[(i+1)%N]   = 1'b1;
               n_ib_k[(i+1)%N]   = ib_k[i];
               n_ib_d[(i+1)%N]   = ib_d[i];
               n_ib_v[i]         = 1'b0;
            end
         end
      end
      if (op_rep || op_ins) begin
         n_ob_v[0] = 1'b1;
         n_ob_k[0] = i_key;
         n_ob_d[0] = i_val;
      end
      if (op_pop)
         n_ob_v[0] = 1'b0;
      if (op_psh) begin
         n_ib_v[0] = 1'b1;
         n_ib_k[0] = i_key;
         n_ib_d[0] = i_val;
      end
      if (op_ins || op_psh)
         n_count = count + CW'(1);
      else if (op_pop)
         n_count = count - CW'(1);
      if (i_flush) begin
         n_ib_v  = '0;
         n_ob_v  = '0;
         n_count = '0;
         n_phase = 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         ib_v      <= '0;
         ob_v      <= '0;
         phase     <= 1'b0;
         count     <= '0;
         push_drop <= 1'b0;
         pop_drop  <= 1'b0;
         for (int i = 0; i < N; i++) begin
            ib_k[i] <= '0;
            ob_k[i] <= '0;
            ib_d[i] <= '0;
            ob_d[i] <= '0;
         end
      end else begin
         ib_v      <= n_ib_v;
         ob_v      <= n_ob_v;
         phase     <= n_phase;
         count     <= n_count;
         push_drop <= n_push_drop;
         pop_drop  <= n_pop_drop;
         for (int i = 0; i < N; i++) begin
            ib_k[i] <= n_ib_k[i];
            ob_k[i] <= n_ob_k[i];
            ib_d[i] <= n_ib_d[i];
            ob_d[i] <= n_ob_d[i];
         end
      end
   end

endmodule
